// File: rtl/prod_matrix_sched_if.sv
// Job / component / completion signal bundle for prod_matrix_sched.
// slave  : the scheduler itself.
// master : the host side that issues jobs, models the HLS component and
//          accepts completions.
interface prod_matrix_sched_if #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int CYC_W = 32
);
    localparam int PEND_W = $clog2(DEPTH) + 1;

    // job descriptor port
    logic              job_valid;
    logic              job_ready;
    logic [63:0]       job_v;
    logic [63:0]       job_r;
    logic [31:0]       job_row;
    logic [31:0]       job_col;
    logic [ID_W-1:0]   job_id;

    // component call/return handshake and arguments
    logic              comp_start;
    logic              comp_busy;
    logic              comp_done;
    logic              comp_stall;
    logic [63:0]       comp_v;
    logic [63:0]       comp_r;
    logic [31:0]       comp_row;
    logic [31:0]       comp_col;

    // completion report
    logic              cpl_valid;
    logic              cpl_ready;
    logic [ID_W-1:0]   cpl_id;
    logic [CYC_W-1:0]  cpl_cycles;

    // status
    logic [PEND_W-1:0] pending;
    logic              idle;
    logic              err_timeout;

    modport slave (
        input  job_valid, job_v, job_r, job_row, job_col, job_id,
        output job_ready,
        output comp_start, comp_stall, comp_v, comp_r, comp_row, comp_col,
        input  comp_busy, comp_done,
        output cpl_valid, cpl_id, cpl_cycles,
        input  cpl_ready,
        output pending, idle, err_timeout
    );

    modport master (
        output job_valid, job_v, job_r, job_row, job_col, job_id,
        input  job_ready,
        input  comp_start, comp_stall, comp_v, comp_r, comp_row, comp_col,
        output comp_busy, comp_done,
        input  cpl_valid, cpl_id, cpl_cycles,
        output cpl_ready,
        input  pending, idle, err_timeout
    );
endinterface

// File: rtl/prod_matrix_sched.sv
// prod_matrix_sched: buffers matrix-product job descriptors in a small FIFO
// and launches the HLS prod_matrix component one job at a time, reporting
// each completion with its id and the call-to-return cycle count.
// Zero-dimension jobs are reported immediately with a cycle count of 0.
// Optional watchdog: define PROD_MATRIX_SCHED_TIMEOUT_EN to enable the sticky
// err_timeout flag; otherwise err_timeout is tied low.
module prod_matrix_sched #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 4,
    parameter int CYC_W   = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic                 clock,
    input  logic                 resetn,
    prod_matrix_sched_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_param
        $error("prod_matrix_sched: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

    // descriptor storage
    logic [63:0]     fifo_v   [DEPTH];
    logic [63:0]     fifo_r   [DEPTH];
    logic [31:0]     fifo_row [DEPTH];
    logic [31:0]     fifo_col [DEPTH];
    logic [ID_W-1:0] fifo_id  [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            head_zero;

    state_t          state;
    logic [63:0]     arg_v;
    logic [63:0]     arg_r;
    logic [31:0]     arg_row;
    logic [31:0]     arg_col;
    logic [ID_W-1:0] arg_id;
    logic            start_q;
    logic            stall_q;
    logic            cpl_valid_q;
    logic [ID_W-1:0] cpl_id_q;
    logic [CYC_W-1:0] cpl_cycles_q;
    logic [CYC_W-1:0] run_cnt;

    // Cycle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] x);
        return (&x) ? x : x + CYC_W'(1);
    endfunction

    // job_ready comes from registered occupancy only, so a same-cycle pop
    // never opens a slot for a push.
    assign full      = (count == PW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = bus.job_valid & ~full;
    assign head_zero = (fifo_row[rd_ptr] == '0) || (fifo_col[rd_ptr] == '0);

    // Head is consumed when idle, or when a completion is accepted and more work waits.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if ((state == REPORT) && bus.cpl_ready)
                pop = 1'b1;
        end
    end

    // Descriptor payload write; contents are only meaningful below count.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_v[wr_ptr]   <= bus.job_v;
            fifo_r[wr_ptr]   <= bus.job_r;
            fifo_row[wr_ptr] <= bus.job_row;
            fifo_col[wr_ptr] <= bus.job_col;
            fifo_id[wr_ptr]  <= bus.job_id;
        end
    end

    // FIFO pointers (wrap naturally at DEPTH) and occupancy.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + PW'(1);
            else if (!push && pop)
                count <= count - PW'(1);
        end
    end

    // Scheduler FSM; a pop at the end overrides the per-state next state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            arg_v        <= '0;
            arg_r        <= '0;
            arg_row      <= '0;
            arg_col      <= '0;
            arg_id       <= '0;
            start_q      <= 1'b0;
            stall_q      <= 1'b1;
            cpl_valid_q  <= 1'b0;
            cpl_id_q     <= '0;
            cpl_cycles_q <= '0;
            run_cnt      <= '0;
        end else begin
            case (state)
                IDLE: ;
                LAUNCH: begin
                    if (!bus.comp_busy) begin
                        start_q <= 1'b0;
                        stall_q <= 1'b0;
                        run_cnt <= CYC_W'(1);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    run_cnt <= sat_inc(run_cnt);
                    if (bus.comp_done) begin
                        cpl_valid_q  <= 1'b1;
                        cpl_id_q     <= arg_id;
                        cpl_cycles_q <= run_cnt;
                        stall_q      <= 1'b1;
                        state        <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.cpl_ready) begin
                        cpl_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                if (head_zero) begin
                    cpl_valid_q  <= 1'b1;
                    cpl_id_q     <= fifo_id[rd_ptr];
                    cpl_cycles_q <= '0;
                    state        <= REPORT;
                end else begin
                    arg_v   <= fifo_v[rd_ptr];
                    arg_r   <= fifo_r[rd_ptr];
                    arg_row <= fifo_row[rd_ptr];
                    arg_col <= fifo_col[rd_ptr];
                    arg_id  <= fifo_id[rd_ptr];
                    start_q <= 1'b1;
                    state   <= LAUNCH;
                end
            end
        end
    end

`ifdef PROD_MATRIX_SCHED_TIMEOUT_EN
    logic err_q;

    // Sticky watchdog: flags a call that has been running TIMEOUT cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            err_q <= 1'b0;
        else if ((state == RUN) && (run_cnt == CYC_W'(TIMEOUT)))
            err_q <= 1'b1;
    end

    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.job_ready  = ~full;
    assign bus.comp_start = start_q;
    assign bus.comp_stall = stall_q;
    assign bus.comp_v     = arg_v;
    assign bus.comp_r     = arg_r;
    assign bus.comp_row   = arg_row;
    assign bus.comp_col   = arg_col;
    assign bus.cpl_valid  = cpl_valid_q;
    assign bus.cpl_id     = cpl_id_q;
    assign bus.cpl_cycles = cpl_cycles_q;
    assign bus.pending    = count;
    assign bus.idle       = (state == IDLE) && empty;

endmodule

// File: tb/tb_prod_matrix_sched.sv
// Bench for prod_matrix_sched: directed scenarios followed by a randomized
// job stream. A queue-based model of submitted jobs predicts launch order,
// launch arguments, completion order, ids and cycle counts; a behavioural
// component responder chooses call-accept stalls and return delays.
`timescale 1ns/1ps
module tb_prod_matrix_sched;
    localparam int DEPTH = 4;
    localparam int ID_W  = 4;
    localparam int CYC_W = 32;
    localparam int TMO   = 50;
`ifdef PROD_MATRIX_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0]     v;
        logic [63:0]     r;
        logic [31:0]     row;
        logic [31:0]     col;
        logic [ID_W-1:0] id;
    } job_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    prod_matrix_sched_if #(.DEPTH(DEPTH), .ID_W(ID_W), .CYC_W(CYC_W)) bus ();

    prod_matrix_sched #(
        .DEPTH(DEPTH), .ID_W(ID_W), .CYC_W(CYC_W), .TIMEOUT(TMO)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    job_t exp_q[$];
    job_t lq[$];
    int   dly_q[$];
    int   busy_hold  = 0;
    int   fixed_d    = 0;
    int   ready_hold = 0;
    bit   rnd_mode   = 1'b0;
    bit   abandon    = 1'b0;
    bit   exp_err    = 1'b0;
    int   n_accept   = 0;
    int   n_cpl      = 0;
    int   n_pushed   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_job(input logic [63:0] v, input logic [63:0] r,
                            input logic [31:0] row, input logic [31:0] col,
                            input logic [ID_W-1:0] id);
        job_t j;
        int   w;
        j.v = v; j.r = r; j.row = row; j.col = col; j.id = id;
        bus.job_v = v; bus.job_r = r; bus.job_row = row; bus.job_col = col; bus.job_id = id;
        bus.job_valid = 1'b1;
        w = 0;
        while ((bus.job_ready !== 1'b1) && (w < 2000)) begin
            tick();
            w++;
        end
        if (w >= 2000) check("push_wait", bus.job_ready, 1);
        tick();
        bus.job_valid = 1'b0;
        exp_q.push_back(j);
        if ((row != 0) && (col != 0)) lq.push_back(j);
        n_pushed++;
    endtask

    task automatic wait_drain(input int lim);
        int w;
        w = 0;
        while (!((exp_q.size() == 0) && (bus.idle === 1'b1) && (bus.cpl_valid === 1'b0)) && (w < lim)) begin
            tick();
            w++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_idle", bus.idle, 1);
        check("drain_pending", bus.pending, 0);
        check("cpl_count", n_cpl, n_pushed);
    endtask

    // Component responder: checks launch arguments, stalls the call, returns after d cycles.
    initial begin : comp_model
        logic [191:0] a0;
        job_t j;
        int d;
        int bh;
        bus.comp_busy = 1'b0;
        bus.comp_done = 1'b0;
        forever begin
            tick();
            if ((bus.comp_start === 1'b1) && !abandon) begin
                a0 = {bus.comp_v, bus.comp_r, bus.comp_row, bus.comp_col};
                check("launch_expected", lq.size() != 0, 1);
                if (lq.size() != 0) begin
                    j = lq.pop_front();
                    check("launch_args", a0, {j.v, j.r, j.row, j.col});
                end
                bh = rnd_mode ? int'($urandom_range(0, 3)) : busy_hold;
                bus.comp_busy = (bh != 0);
                for (int i = 0; i < bh; i++) begin
                    tick();
                    check("busy_start", bus.comp_start, 1);
                    check("busy_args", {bus.comp_v, bus.comp_r, bus.comp_row, bus.comp_col}, a0);
                    check("busy_stall", bus.comp_stall, 1);
                end
                bus.comp_busy = 1'b0;
                tick();
                n_accept++;
                check("accept_start_low", bus.comp_start, 0);
                check("accept_stall", bus.comp_stall, 0);
                d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 30));
                dly_q.push_back(d);
                for (int k = 1; k < d; k++) begin
                    tick();
                    if (abandon) break;
                    if (TMO_EN && (k >= TMO)) exp_err = 1'b1;
                    check("run_start_low", bus.comp_start, 0);
                    check("run_stall", bus.comp_stall, 0);
                    check("run_args", {bus.comp_v, bus.comp_r, bus.comp_row, bus.comp_col}, a0);
                    check("run_err", bus.err_timeout, exp_err);
                end
                if (!abandon) begin
                    bus.comp_done = 1'b1;
                    tick();
                    bus.comp_done = 1'b0;
                    if (TMO_EN && (d >= TMO)) exp_err = 1'b1;
                    check("cpl_latency", bus.cpl_valid, 1);
                    check("done_stall", bus.comp_stall, 1);
                    check("done_err", bus.err_timeout, exp_err);
                end
            end
        end
    end

    // Completion consumer: optionally withholds cpl_ready, then checks against the model.
    initial begin : consumer
        logic [ID_W-1:0]  id0;
        logic [CYC_W-1:0] cy0;
        job_t j;
        int h;
        int ecy;
        bus.cpl_ready = 1'b0;
        forever begin
            if ((bus.cpl_valid === 1'b1) && !abandon) begin
                id0 = bus.cpl_id;
                cy0 = bus.cpl_cycles;
                h = rnd_mode ? int'($urandom_range(0, 3)) : ready_hold;
                for (int i = 0; i < h; i++) begin
                    tick();
                    check("hold_valid", bus.cpl_valid, 1);
                    check("hold_id", bus.cpl_id, id0);
                    check("hold_cycles", bus.cpl_cycles, cy0);
                    check("hold_stall", bus.comp_stall, 1);
                    check("hold_no_launch", bus.comp_start, 0);
                end
                bus.cpl_ready = 1'b1;
                check("cpl_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    j = exp_q.pop_front();
                    check("cpl_id", bus.cpl_id, j.id);
                    if ((j.row == 0) || (j.col == 0)) begin
                        ecy = 0;
                    end else begin
                        check("cpl_has_delay", dly_q.size() != 0, 1);
                        ecy = (dly_q.size() != 0) ? dly_q.pop_front() : -1;
                    end
                    check("cpl_cycles", bus.cpl_cycles, ecy);
                end
                n_cpl++;
                tick();
                bus.cpl_ready = 1'b0;
            end else begin
                tick();
            end
        end
    end

    task automatic check_reset_values(input string pfx);
        check({pfx, "_job_ready"}, bus.job_ready, 1);
        check({pfx, "_idle"}, bus.idle, 1);
        check({pfx, "_comp_stall"}, bus.comp_stall, 1);
        check({pfx, "_comp_start"}, bus.comp_start, 0);
        check({pfx, "_cpl_valid"}, bus.cpl_valid, 0);
        check({pfx, "_pending"}, bus.pending, 0);
        check({pfx, "_err"}, bus.err_timeout, 0);
        check({pfx, "_args"}, {bus.comp_v, bus.comp_r, bus.comp_row, bus.comp_col}, 0);
        check({pfx, "_cpl_id"}, bus.cpl_id, 0);
        check({pfx, "_cpl_cycles"}, bus.cpl_cycles, 0);
    endtask

    initial begin : main
        int a_before;
        int n;
        int w;
        logic [31:0] rr;
        logic [31:0] cc;
        bus.job_valid = 1'b0;
        bus.job_v = '0; bus.job_r = '0; bus.job_row = '0; bus.job_col = '0; bus.job_id = '0;
        repeat (3) tick();
        check_reset_values("rst");
        resetn = 1'b1;
        tick();

        // single job: 2-cycle launch latency, 20-cycle return
        fixed_d = 20; busy_hold = 0;
        a_before = n_accept;
        push_job(64'h1000, 64'h2000, 3, 3, 5);
        check("lat_not_idle", bus.idle, 0);
        check("lat_start_early", bus.comp_start, 0);
        tick();
        check("lat_start", bus.comp_start, 1);
        wait_drain(500);
        check("single_launch", n_accept - a_before, 1);

        // call held off by comp_busy for 7 cycles
        fixed_d = 5; busy_hold = 7;
        a_before = n_accept;
        push_job(64'hABCD_0000_1234, 64'h5555_AAAA, 17, 9, 1);
        tick();
        n = 0;
        while ((bus.comp_start === 1'b1) && (n < 50)) begin
            n++;
            tick();
        end
        check("launch_len", n, 8);
        wait_drain(500);
        check("busy_single_launch", n_accept - a_before, 1);

        // five back-to-back jobs against a stalled component
        fixed_d = 8; busy_hold = 10;
        for (int i = 0; i < 5; i++)
            push_job({$urandom, $urandom}, {$urandom, $urandom}, 32'(i + 1), 32'(i + 2), ID_W'(i));
        check("full_pending", bus.pending, 4);
        check("full_ready", bus.job_ready, 0);
        wait_drain(1000);

        // zero-dimension jobs between normal jobs
        fixed_d = 0; busy_hold = 0;
        a_before = n_accept;
        push_job(64'h11, 64'h22, 2, 2, 1);
        push_job(64'h33, 64'h44, 0, 5, 9);
        push_job(64'h55, 64'h66, 6, 0, 10);
        push_job(64'h77, 64'h88, 4, 4, 2);
        wait_drain(500);
        check("zero_launches", n_accept - a_before, 2);

        // completion back-pressure with work queued behind it
        fixed_d = 4; ready_hold = 10;
        push_job(64'h100, 64'h200, 8, 8, 3);
        push_job(64'h300, 64'h400, 2, 7, 4);
        wait_drain(500);
        ready_hold = 0;

        // randomized job stream
        rnd_mode = 1'b1; fixed_d = 0;
        for (int i = 0; i < 40; i++) begin
            rr = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 100));
            cc = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 100));
            push_job({$urandom, $urandom}, {$urandom, $urandom}, rr, cc, ID_W'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain(5000);
        rnd_mode = 1'b0;

        // long job crossing the watchdog limit
        fixed_d = 60;
        push_job(64'hDEAD, 64'hBEEF, 10, 10, 7);
        wait_drain(500);
        check("err_after_long", bus.err_timeout, TMO_EN);

        // reset in the middle of a call with two jobs queued
        fixed_d = 200;
        a_before = n_accept;
        push_job(64'hA, 64'hB, 5, 5, 11);
        push_job(64'hC, 64'hD, 5, 5, 12);
        push_job(64'hE, 64'hF, 5, 5, 13);
        w = 0;
        while ((n_accept == a_before) && (w < 100)) begin
            tick();
            w++;
        end
        check("rst_launched", n_accept > a_before, 1);
        repeat (5) tick();
        check("rst_pre_pending", bus.pending, 2);
        check("rst_pre_stall", bus.comp_stall, 0);
        #2;
        abandon = 1'b1;
        resetn = 1'b0;
        #1;
        check_reset_values("arst");
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        check("post_rst_pending", bus.pending, 0);
        check("post_rst_idle", bus.idle, 1);
        check("post_rst_start", bus.comp_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
